// File: rtl/key_event_decoder.sv
// key_event_decoder
//   Turns the debounced key level into single-cycle key events (press,
//   release, long-press, auto-repeat) for the time-set control FSM.
//   Timing comes from an internal tick prescaler counting CLK cycles.
//
// Ports:
//   CLK         in   system clock, rising edge
//   RST         in   synchronous reset, active-high
//   Key_In      in   debounced key level, 1 = pressed (synchronous to CLK)
//   Repeat_En   in   1 = enter auto-repeat after a long press
//   Press_Sig   out  one-cycle pulse on press
//   Release_Sig out  one-cycle pulse on release
//   Long_Sig    out  one-cycle pulse when the hold reaches LONG_MS ticks
//   Repeat_Sig  out  one-cycle pulse every REPEAT_MS ticks in auto-repeat
//   Key_Held    out  level, 1 while the FSM is not IDLE
module key_event_decoder #(
  parameter int unsigned TICK_DIV  = 6,
  parameter int unsigned LONG_MS   = 10,
  parameter int unsigned REPEAT_MS = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic Key_In,
  input  logic Repeat_En,
  output logic Press_Sig,
  output logic Release_Sig,
  output logic Long_Sig,
  output logic Repeat_Sig,
  output logic Key_Held
);

  localparam int unsigned CNT_W = 8;

  localparam logic [CNT_W-1:0] TICK_LAST   = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_MS - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_MS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESSED = 2'd1,
    S_REPEAT  = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               key_q, key_d;
  logic [CNT_W-1:0]   presc_q, presc_d;
  logic [CNT_W-1:0]   ms_q, ms_d;
  logic               press_q, press_d;
  logic               rel_q, rel_d;
  logic               long_q, long_d;
  logic               rpt_q, rpt_d;
  logic               held_q, held_d;

  logic               press_edge_c;
  logic               rel_edge_c;
  logic               tick_c;

  assign press_edge_c = Key_In & ~key_q;
  assign rel_edge_c   = ~Key_In & key_q;
  assign tick_c       = (presc_q == TICK_LAST);

  // Next-state, counter and event logic
  always_comb begin
    state_d = state_q;
    key_d   = Key_In;
    presc_d = tick_c ? '0 : presc_q + CNT_W'(1);
    ms_d    = tick_c ? ms_q + CNT_W'(1) : ms_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    long_d  = 1'b0;
    rpt_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Counters parked at zero so the press edge starts a clean hold
        presc_d = '0;
        ms_d    = '0;
        if (press_edge_c) begin
          press_d = 1'b1;
          state_d = S_PRESSED;
        end
      end
      S_PRESSED: begin
        // Release wins over a long threshold landing on the same edge
        if (rel_edge_c) begin
          rel_d   = 1'b1;
          state_d = S_IDLE;
        end else if (tick_c && (ms_q == LONG_LAST)) begin
          long_d = 1'b1;
          if (Repeat_En) begin
            state_d = S_REPEAT;
            ms_d    = '0;
          end else begin
            state_d = S_HOLD;
          end
        end
      end
      S_REPEAT: begin
        if (rel_edge_c) begin
          rel_d   = 1'b1;
          state_d = S_IDLE;
        end else if (!Repeat_En) begin
          state_d = S_HOLD;
        end else if (tick_c && (ms_q == REPEAT_LAST)) begin
          rpt_d = 1'b1;
          ms_d  = '0;
        end
      end
      S_HOLD: begin
        if (rel_edge_c) begin
          rel_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    held_d = (state_d != S_IDLE);
  end

  // State and output registers; history reset to 1 so a key held
  // through reset never reports a press
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      key_q   <= 1'b1;
      presc_q <= '0;
      ms_q    <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
      rpt_q   <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      presc_q <= presc_d;
      ms_q    <= ms_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      rpt_q   <= rpt_d;
      held_q  <= held_d;
    end
  end

  assign Press_Sig   = press_q;
  assign Release_Sig = rel_q;
  assign Long_Sig    = long_q;
  assign Repeat_Sig  = rpt_q;
  assign Key_Held    = held_q;

endmodule
